// File: rtl/issue_queue_alloc_requester_pkg.sv
// Shared types for the issue-queue allocation requester: index path, group record, FSM states.
package issue_queue_alloc_requester_pkg;

    localparam int RENAME_WIDTH_DEF   = 2;
    localparam int IQ_INDEX_WIDTH_DEF = 4;

    typedef logic [IQ_INDEX_WIDTH_DEF-1:0] IssueQueueIndexPath;

    // One rename group as held in the group FIFO.
    typedef struct packed {
        logic [RENAME_WIDTH_DEF-1:0]         laneValid;
        IssueQueueIndexPath [RENAME_WIDTH_DEF-1:0] ptr;
    } IQAllocGroup;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } IQAllocState;

endpackage

// File: rtl/issue_queue_alloc_requester_if.sv
// Rename / allocator / dispatch / return signals of the issue-queue allocation requester.
interface issue_queue_alloc_requester_if #(
    parameter int RENAME_WIDTH   = 2,
    parameter int IQ_INDEX_WIDTH = 4
);
    localparam int PTR_W = RENAME_WIDTH * IQ_INDEX_WIDTH;

    logic                    renGroupValid;
    logic [RENAME_WIDTH-1:0] renLaneValid;
    logic                    renReady;
    logic                    allocatable;
    logic [RENAME_WIDTH-1:0] allocate;
    logic [PTR_W-1:0]        allocatedPtr;
    logic                    dispValid;
    logic [RENAME_WIDTH-1:0] dispLaneValid;
    logic [PTR_W-1:0]        dispPtr;
    logic                    dispReady;
    logic                    flush;
    logic [RENAME_WIDTH-1:0] retValid;
    logic [PTR_W-1:0]        retPtr;
    logic                    busy;

    modport master (
        input  renGroupValid, renLaneValid, allocatable, allocatedPtr, dispReady, flush,
        output renReady, allocate, dispValid, dispLaneValid, dispPtr, retValid, retPtr, busy
    );

    modport slave (
        output renGroupValid, renLaneValid, allocatable, allocatedPtr, dispReady, flush,
        input  renReady, allocate, dispValid, dispLaneValid, dispPtr, retValid, retPtr, busy
    );

endinterface

// File: rtl/issue_queue_alloc_requester_group_fifo.sv
// Group FIFO for allocated IQ indices; head/tail wrap by compare so any depth >= 2 works.
module iq_alloc_group_fifo #(
    parameter int DEPTH   = 2,
    parameter int GROUP_W = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [GROUP_W-1:0]             pushGroup,
    input  logic                           pop,
    output logic [GROUP_W-1:0]             headGroup,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [GROUP_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   tail;

    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= nextIdx(tail);
            if (pop)  head <= nextIdx(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= pushGroup;
    end

    assign headGroup = mem[head];
    assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/issue_queue_alloc_requester.sv
// Rename-side issue-queue allocation requester with flush drain back to the free list.
// Optional same-cycle empty-FIFO bypass to dispatch when IQ_ALLOC_BYPASS_EN is defined.
module issue_queue_alloc_requester
    import issue_queue_alloc_requester_pkg::*;
#(
    parameter int RENAME_WIDTH   = RENAME_WIDTH_DEF,
    parameter int IQ_INDEX_WIDTH = IQ_INDEX_WIDTH_DEF,
    parameter int GROUP_DEPTH    = 2
) (
    input logic clk,
    input logic rst_n,
    issue_queue_alloc_requester_if.master io
);
    localparam int PTR_W   = RENAME_WIDTH * IQ_INDEX_WIDTH;
    localparam int GROUP_W = RENAME_WIDTH + PTR_W;
    localparam int CNT_W   = $clog2(GROUP_DEPTH + 1);

    IQAllocState             state;
    logic [CNT_W-1:0]        count;
    logic                    full;
    logic                    empty;
    logic                    idle;
    logic                    accept;
    logic                    bypass;
    logic                    headValid;
    logic                    push;
    logic                    pop;
    logic [GROUP_W-1:0]      headGroup;
    logic [RENAME_WIDTH-1:0] headLaneValid;
    logic [PTR_W-1:0]        headPtr;

    assign {headLaneValid, headPtr} = headGroup;

    assign idle      = (state == IDLE);
    assign empty     = (count == '0);
    assign accept    = io.renGroupValid && io.allocatable && !full && idle && !io.flush;
    assign headValid = !empty && idle && !io.flush;

`ifdef IQ_ALLOC_BYPASS_EN
    assign bypass = accept && empty && io.dispReady;
`else
    assign bypass = 1'b0;
`endif

    // Every DRAIN cycle retires one group, so the FIFO is popped unconditionally there.
    assign push = accept && !bypass;
    assign pop  = (headValid && io.dispReady) || !idle;

    iq_alloc_group_fifo #(
        .DEPTH   (GROUP_DEPTH),
        .GROUP_W (GROUP_W)
    ) groupFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pushGroup ({io.renLaneValid, io.allocatedPtr}),
        .pop       (pop),
        .headGroup (headGroup),
        .count     (count),
        .full      (full)
    );

    assign io.renReady = accept;
    assign io.allocate = {RENAME_WIDTH{accept}} & io.renLaneValid;

`ifdef IQ_ALLOC_BYPASS_EN
    assign io.dispValid     = headValid || bypass;
    assign io.dispLaneValid = bypass ? io.renLaneValid : (headValid ? headLaneValid : '0);
    assign io.dispPtr       = bypass ? io.allocatedPtr : (headValid ? headPtr : '0);
`else
    assign io.dispValid     = headValid;
    assign io.dispLaneValid = headValid ? headLaneValid : '0;
    assign io.dispPtr       = headValid ? headPtr : '0;
`endif

    assign io.retValid = idle ? '0 : headLaneValid;
    assign io.retPtr   = idle ? '0 : headPtr;
    assign io.busy     = !idle;

    // Flush suppresses push/pop, so the count seen here is the count after the flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (io.flush && !empty) state <= DRAIN;
                DRAIN:   if (count == CNT_W'(1)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
